// File: rtl/bmc_rst_sequencer.sv
// BMC reset sequencer: arbitrates reset requests and sequences the BMC system, SSP,
// external and PCIe resets on a shared 1 ms tick.
module bmc_rst_sequencer #(
   parameter int unsigned POR_DLY_MS  = 100,
   parameter int unsigned SSP_DLY_MS  = 5,
   parameter int unsigned ASSERT_MS   = 10,
   parameter int unsigned PCIE_DLY_MS = 100,
   parameter int unsigned NREQ        = 3
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_int_1ms_en,
   input  logic [NREQ-1:0] i_rst_req,
   input  logic            i_rc_pcie_rst,
   output logic            o_bmc_srst,
   output logic            o_bmc_ssprst,
   output logic            o_bmc_extrst,
   output logic            o_bmc_pcie_rst,
   output logic [1:0]      o_rst_cause,
   output logic [7:0]      o_rst_cnt,
   output logic            o_busy
);

   typedef enum logic [2:0] {
      StPor     = 3'd0,
      StRelSrst = 3'd1,
      StRun     = 3'd2,
      StAssert  = 3'd3,
      StHold    = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_d;

   logic [NREQ-1:0]   r_req_s1;
   logic [NREQ-1:0]   r_req_s2;
   logic              r_pcie_s1;
   logic              r_pcie_s2;

   logic [7:0]        r_ms_cnt;
   logic [7:0]        w_ms_cnt_d;
   logic [15:0]       r_pcie_cnt;
   logic [15:0]       w_pcie_cnt_d;

   logic [1:0]        r_req_idx;
   logic [1:0]        r_cause;
   logic [7:0]        r_cnt;
   logic              r_srst;
   logic              r_ssp;
   logic              r_pcie;
   logic              r_busy;

   logic [3:0]        w_req_pad;
   logic [1:0]        w_req_idx;
   logic              w_any_req;
   logic              w_cap_hi;
   logic              w_capture;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_req_s1  <= '0;
         r_req_s2  <= '0;
         r_pcie_s1 <= 1'b0;
         r_pcie_s2 <= 1'b0;
      end else begin
         r_req_s1  <= i_rst_req;
         r_req_s2  <= r_req_s1;
         r_pcie_s1 <= i_rc_pcie_rst;
         r_pcie_s2 <= r_pcie_s1;
      end
   end

   // Zero-padded so the captured index can address any NREQ without range issues.
   always_comb begin
      w_req_pad = '0;
      w_req_pad[NREQ-1:0] = r_req_s2;
      w_req_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_req_pad[i]) w_req_idx = 2'(i);
      end
   end

   assign w_any_req = |r_req_s2;
   assign w_cap_hi  = w_req_pad[r_req_idx];

   always_comb begin
      w_state_d = r_state;
      w_capture = 1'b0;
      case (r_state)
         StPor: begin
            if (i_int_1ms_en && (r_ms_cnt == 8'(POR_DLY_MS - 1))) w_state_d = StRelSrst;
         end
         StRelSrst: begin
            if (i_int_1ms_en && (r_ms_cnt == 8'(SSP_DLY_MS - 1))) w_state_d = StRun;
         end
         StRun: begin
            if (w_any_req) begin
               w_capture = 1'b1;
               w_state_d = StAssert;
            end
         end
         StAssert: begin
            if (i_int_1ms_en && (r_ms_cnt == 8'(ASSERT_MS - 1))) begin
               w_state_d = w_cap_hi ? StHold : StRelSrst;
            end
         end
         StHold: begin
            if (!w_cap_hi) w_state_d = StRelSrst;
         end
         default: w_state_d = StPor;
      endcase
   end

   // The ms timer restarts on every state change; a tick in the entry cycle counts.
   always_comb begin
      w_ms_cnt_d = r_ms_cnt;
      if (w_state_d != r_state) begin
         w_ms_cnt_d = '0;
      end else if (i_int_1ms_en) begin
         w_ms_cnt_d = r_ms_cnt + 8'd1;
      end
   end

   // Clearing on the next state makes leaving S_RUN drop PCIe reset on the same edge.
   always_comb begin
      w_pcie_cnt_d = r_pcie_cnt;
      if ((w_state_d != StRun) || !r_pcie_s2) begin
         w_pcie_cnt_d = '0;
      end else if (i_int_1ms_en && (r_state == StRun) &&
                   (r_pcie_cnt != 16'(PCIE_DLY_MS))) begin
         w_pcie_cnt_d = r_pcie_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StPor;
         r_ms_cnt   <= '0;
         r_pcie_cnt <= '0;
         r_req_idx  <= '0;
         r_cause    <= '0;
         r_cnt      <= '0;
         r_srst     <= 1'b0;
         r_ssp      <= 1'b0;
         r_pcie     <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_state_d;
         r_ms_cnt   <= w_ms_cnt_d;
         r_pcie_cnt <= w_pcie_cnt_d;
         if (w_capture) begin
            r_req_idx <= w_req_idx;
            r_cause   <= w_req_idx + 2'd1;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
         end
         r_srst <= (w_state_d == StRelSrst) || (w_state_d == StRun);
         r_ssp  <= (w_state_d == StRun);
         r_pcie <= (w_pcie_cnt_d == 16'(PCIE_DLY_MS));
         r_busy <= (w_state_d != StRun);
      end
   end

   assign o_bmc_srst     = r_srst;
   assign o_bmc_ssprst   = r_ssp;
   assign o_bmc_extrst   = r_ssp;
   assign o_bmc_pcie_rst = r_pcie;
   assign o_rst_cause    = r_cause;
   assign o_rst_cnt      = r_cnt;
   assign o_busy         = r_busy;

endmodule

// File: doc/bmc_rst_sequencer.md
Name: bmc_rst_sequencer

Overview:
Top-level BMC reset sequencer in the CPLD.
- Arbitrates BMC reset requests from several sources (watchdog, front-panel, host software).
- Sequences the BMC system, SSP and external resets with ms-granular, parameterised delays.
- Gates the BMC PCIe reset on the host root-complex reset, but only once the BMC is out of reset.
- Timebase: the shared 1 ms tick.

Parameters:
- POR_DLY_MS, 100: ms after reset deassertion before bmc_srst releases (range 1..255).
- SSP_DLY_MS, 5: ms between bmc_srst release and bmc_ssprst/bmc_extrst release (1..255).
- ASSERT_MS, 10: minimum ms all BMC resets are held low for a request (1..255).
- PCIE_DLY_MS, 100: ms rc_pcie_rst must be high before bmc_pcie_rst releases (1..65535).
- NREQ, 3: number of request inputs (1..3).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- int_1ms_en, in, 1: one-cycle pulse every 1 ms, synchronous to clock.
- rst_req, in, NREQ: level, active-high BMC reset requests; asynchronous, 2-flop synchronised internally.
- rc_pcie_rst, in, 1: host PCIe reset, active-low; asynchronous, 2-flop synchronised internally.
- bmc_srst, out, 1: BMC system reset, active-low (0 = in reset).
- bmc_ssprst, out, 1: BMC SSP reset, active-low.
- bmc_extrst, out, 1: BMC external reset, active-low.
- bmc_pcie_rst, out, 1: BMC PCIe reset, active-low.
- rst_cause, out, 2: cause of last reset; 0 = power-on, k+1 = rst_req[k].
- rst_cnt, out, 8: accepted request count, saturates at 255.
- busy, out, 1: high whenever the FSM is not in S_RUN.

Behaviour:
Reset values (all outputs and internal state):
- bmc_srst, bmc_ssprst, bmc_extrst, bmc_pcie_rst = 0.
- rst_cause = 0, rst_cnt = 0, busy = 1, FSM = S_POR, all counters and sync flops = 0.

Timer rule:
- One shared 8-bit ms counter, cleared on every state entry.
- Increments only on cycles where int_1ms_en = 1.
- A wait of N ms exits on the clock edge where int_1ms_en = 1 and counter = N-1.
- Outputs therefore change 1 cycle after the Nth tick.
- Ticks in the entry cycle count.

FSM:
- S_POR: all four outputs 0. After POR_DLY_MS -> S_REL_SRST.
- S_REL_SRST: bmc_srst = 1; ssprst/extrst/pcie_rst = 0. After SSP_DLY_MS -> S_RUN, with bmc_ssprst = bmc_extrst = 1 registered on the transition.
- S_RUN: busy = 0.
  - If any synchronised rst_req bit is high, capture the lowest-index high bit k.
  - rst_cause <= k+1; rst_cnt <= rst_cnt+1 (saturating at 255).
  - All four outputs <= 0 on the same edge; -> S_ASSERT.
- S_ASSERT: outputs held 0. After ASSERT_MS:
  - captured request still high -> S_HOLD;
  - captured request low -> S_REL_SRST.
- S_HOLD: outputs held 0. Leave for S_REL_SRST on the first cycle the captured bit is low.
- Unused encodings -> S_POR.

Request handling:
- Level-sensitive; requests are only sampled in S_RUN. No queueing.
- A non-captured request still high when S_RUN is re-entered triggers a new sequence 1 cycle later.

PCIe path:
- 16-bit counter.
- Cleared while the FSM is not in S_RUN or the synchronised rc_pcie_rst = 0.
- Increments on ticks while the FSM is in S_RUN and rc_pcie_rst is high, stopping at PCIE_DLY_MS.
- bmc_pcie_rst = 1 iff the counter = PCIE_DLY_MS.

bmc_pcie_rst falling edges:
- Synchronised rc_pcie_rst falling -> bmc_pcie_rst 0 on the next edge, counter cleared; the FSM is unaffected.
- Leaving S_RUN also forces bmc_pcie_rst 0 on the same edge.
- An rc_pcie_rst already high on S_RUN entry starts counting immediately.

Asynchronous reset mid-sequence:
- Immediate return to reset values.
- rst_cnt and rst_cause cleared.

Test Plan:
Bench parameters: POR_DLY_MS=4, SSP_DLY_MS=2, ASSERT_MS=3, PCIE_DLY_MS=5, NREQ=3; int_1ms_en every 10 clocks; rc_pcie_rst high throughout unless stated.

1. Power-on: release reset, rst_req = 0.
   - bmc_srst rises 1 cycle after the 4th tick.
   - ssprst/extrst rise 1 cycle after the 6th tick.
   - bmc_pcie_rst rises 1 cycle after the 11th tick.
   - rst_cause = 0, busy falls with ssprst.
2. Request pulse: in S_RUN, pulse rst_req[1] for 1 ms.
   - All outputs 0 three cycles after the input edge (2-flop sync + 1).
   - rst_cause = 2, rst_cnt = 1.
   - bmc_srst returns 1 cycle after the 3rd tick; ssprst 2 ticks later; pcie_rst 5 ticks after that.
3. Simultaneous and held requests: rst_req = 3'b110, held 20 ms, then dropped together.
   - rst_cause = 2; FSM sits in S_HOLD with outputs 0.
   - Release sequence starts on the drop; rst_cnt increments once.
4. PCIe toggle: in S_RUN, drop rc_pcie_rst for 2 ms, then raise it.
   - bmc_pcie_rst goes 0 three cycles after the fall.
   - Returns 1 only after 5 further ticks; bmc_srst stays 1.
5. Async reset mid-S_ASSERT: assert reset.
   - All outputs 0 combinationally; rst_cnt = 0.
   - After release, the full power-on sequence of test 1 repeats.
6. Saturation: issue 260 request pulses.
   - rst_cnt = 255 and holds.
